led_scan_receiver: RTL and testbench
====================================

LED_SCAN_RECEIVER -- requirements
Module: led_scan_receiver

Interface
REQ-001 Parameter: SETTLE_CYCLES, 8, consecutive stable cycles required before a digit is sampled (legal range 1..255).
REQ-002 Parameter: TIMEOUT_CYCLES, 1024, frame-assembly timeout used only when SCAN_TIMEOUT_EN is defined (legal range 2..65535).
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: an3, an2, an1, an0  input  1 each  multiplexed digit anodes, active-low; an3 is the leftmost digit.
REQ-006 Port: a, b, c, d, e, f, g  input  1 each  shared segment lines, active-low.
REQ-007 Port: dp  input  1  decimal point; ignored.
REQ-008 Port: data_out  output  16  last complete word; an3 digit in [15:12], an2 in [11:8], an1 in [7:4], an0 in [3:0].
REQ-009 Port: data_valid  output  1  one-cycle pulse when data_out is updated.
REQ-010 Port: seg_error  output  1  one-cycle pulse when a settled digit carries a pattern not in the decode table.
REQ-011 Port: scan_timeout  output  1  one-cycle pulse on frame timeout.

Function
REQ-012 Inputs are registered once; all decisions use the registered values, giving one cycle of input latency.
REQ-013 Window qualifier: exactly one anode low = "window active"; zero or more than one anode low = "blank".
REQ-014 Stable counter: increments, saturating at SETTLE_CYCLES, each cycle the window is active and {an3..an0, a..g} equals the previous registered value; any change or blank cycle clears it to 0 and clears the window-sampled flag.
REQ-015 Sample: on the cycle the counter first reaches SETTLE_CYCLES with the window-sampled flag clear, decode the segments once and set the flag; there is no further sampling until the window changes.
REQ-016 Decode table {a,b,c,d,e,f,g}: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-017 Valid pattern: write the nibble into the frame slot for the active anode and set that slot's bit in the 4-bit capture mask; re-capturing an already-set slot overwrites it.
REQ-018 Invalid pattern: pulse seg_error the following cycle and leave the slot and mask unchanged.
REQ-019 Frame complete: the cycle after the mask reaches 1111, load data_out from the frame, pulse data_valid for exactly one cycle, and clear the mask. If a new sample arrives in that same cycle, it is applied after the clear.
REQ-020 data_out holds its value between data_valid pulses; data_valid and seg_error are never asserted for more than one cycle per event.
REQ-021 States: IDLE (blank), SETTLING (window active, counter < SETTLE_CYCLES), SAMPLED (flag set), COMMIT (frame complete). Transitions follow REQ-014..REQ-019.

Reset
REQ-022 While reset is low: data_out=16'h0000; data_valid, seg_error and scan_timeout = 0; mask, frame, counters, flag and input registers cleared; state IDLE.
REQ-023 Reset asserted mid-frame discards the partial frame; the first frame after release requires four fresh captures.

Configuration
REQ-024 Macro SCAN_TIMEOUT_EN defined: a frame timer counts every cycle while the mask is non-zero and restarts on each capture. On reaching TIMEOUT_CYCLES, pulse scan_timeout for one cycle and clear the mask and timer.
REQ-025 Macro SCAN_TIMEOUT_EN undefined: no timer is built, scan_timeout is tied to 0, and a partial mask persists indefinitely.

Verification
REQ-026 Scan 16'h3A7F with a 16-cycle window per digit, in order an2, an1, an0, an3 -> data_valid pulses once per full rotation, data_out=16'h3A7F.
REQ-027 Window of 5 cycles with SETTLE_CYCLES=8 -> no capture and no data_valid; data_out unchanged.
REQ-028 Pattern 1111111 on an1 -> single seg_error pulse, mask bit 1 unset; the next valid rotation completes normally.
REQ-029 an3 and an0 low together for 20 cycles -> treated as blank, no capture, no pulses.
REQ-030 Reset driven low after three digits captured, then a full scan of 16'hBEEF -> exactly one data_valid, with data_out=16'hBEEF.
REQ-031 SCAN_TIMEOUT_EN defined: capture only the an3 digit, then blank for 1024 cycles -> scan_timeout pulse, mask cleared; without the macro, scan_timeout stays 0.

Source files
------------

// File: rtl/led_scan_receiver.sv
// ---------------------------------------------------------------------------
// led_scan_receiver
//   Recovers a 16-bit hex word from a multiplexed 4-digit, 7-segment LED
//   drive. The anode and segment lines are registered once. A digit is
//   sampled after its window has held steady for SETTLE_CYCLES cycles.
//   When all four digit slots are captured, the assembled word is published.
//
//   Optional feature (macro SCAN_TIMEOUT_EN):
//     When defined, a partial frame is abandoned if no capture occurs within
//     TIMEOUT_CYCLES cycles, and scan_timeout pulses.
//     When undefined, scan_timeout is tied low and a partial frame persists.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   an3..an0       digit anodes, active-low (an3 = leftmost digit)
//   a..g           segment lines, active-low
//   dp             decimal point (ignored)
//   data_out       last complete word {an3, an2, an1, an0} nibbles
//   data_valid     one-cycle pulse when data_out is updated
//   seg_error      one-cycle pulse when a settled digit has an unknown pattern
//   scan_timeout   one-cycle pulse when a partial frame times out
// ---------------------------------------------------------------------------
module led_scan_receiver #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        an3,
    input  logic        an2,
    input  logic        an1,
    input  logic        an0,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic        dp,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        seg_error,
    output logic        scan_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLING = 2'd1,
        ST_SAMPLED  = 2'd2,
        ST_COMMIT   = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);

    // Segment pattern {a..g} (active-low) to {valid, nibble}.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'b0000001: seg_decode = {1'b1, 4'h0};
            7'b1001111: seg_decode = {1'b1, 4'h1};
            7'b0010010: seg_decode = {1'b1, 4'h2};
            7'b0000110: seg_decode = {1'b1, 4'h3};
            7'b1001100: seg_decode = {1'b1, 4'h4};
            7'b0100100: seg_decode = {1'b1, 4'h5};
            7'b0100000: seg_decode = {1'b1, 4'h6};
            7'b0001111: seg_decode = {1'b1, 4'h7};
            7'b0000000: seg_decode = {1'b1, 4'h8};
            7'b0000100: seg_decode = {1'b1, 4'h9};
            7'b0001000: seg_decode = {1'b1, 4'hA};
            7'b1100000: seg_decode = {1'b1, 4'hB};
            7'b0110001: seg_decode = {1'b1, 4'hC};
            7'b1000010: seg_decode = {1'b1, 4'hD};
            7'b0110000: seg_decode = {1'b1, 4'hE};
            7'b0111000: seg_decode = {1'b1, 4'hF};
            default:    seg_decode = {1'b0, 4'h0};
        endcase
    endfunction

    // {an3..an0, a..g} as registered this cycle and the cycle before
    logic [10:0] in_r;
    logic [10:0] prev_r;
    logic [7:0]  cnt_r;
    logic        sampled_r;
    logic [3:0]  mask_r;
    logic [15:0] frame_r;
    state_t      state_r;
    logic [15:0] data_out_r;
    logic        data_valid_r;
    logic        seg_error_r;
    logic        scan_timeout_r;

    logic [3:0]  an_low_s;
    logic        window_s;
    logic        stable_s;
    logic [7:0]  cnt_next_s;
    logic        sample_s;
    logic [4:0]  dec_s;
    logic        capture_s;
    logic        commit_s;
    logic        timeout_s;
    logic        sampled_next_s;
    logic [3:0]  mask_next_s;
    logic [15:0] frame_next_s;
    state_t      state_next_s;
    logic        unused_s;

    assign unused_s = dp;

    // Window qualification, settle counting and sample decision.
    always_comb begin
        an_low_s   = ~in_r[10:7];
        // exactly one anode low: non-zero and a power of two
        window_s   = (an_low_s != 4'd0) && ((an_low_s & (an_low_s - 4'd1)) == 4'd0);
        stable_s   = window_s && (in_r == prev_r);
        if (stable_s) begin
            cnt_next_s = (cnt_r == SETTLE_MAX) ? SETTLE_MAX : (cnt_r + 8'd1);
        end else begin
            cnt_next_s = 8'd0;
        end
        sample_s       = stable_s && !sampled_r && (cnt_next_s == SETTLE_MAX);
        dec_s          = seg_decode(in_r[6:0]);
        capture_s      = sample_s && dec_s[4];
        sampled_next_s = stable_s && (sampled_r || sample_s);
        commit_s       = (state_r == ST_COMMIT);
    end

`ifdef SCAN_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] timer_r;

    // A capture restarts the timer, so it cannot time out in the same cycle.
    always_comb begin
        timeout_s = !commit_s && !capture_s && (mask_r != 4'd0) && (timer_r == TIMEOUT_LAST);
    end

    // Frame timer: runs while a partial frame is pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_r <= 16'd0;
        end else if (capture_s || commit_s || timeout_s || (mask_r == 4'd0)) begin
            timer_r <= 16'd0;
        end else begin
            timer_r <= timer_r + 16'd1;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Frame/mask update; a commit or timeout clears the mask before a new capture lands.
    always_comb begin
        if (commit_s || timeout_s) begin
            mask_next_s = 4'd0;
        end else begin
            mask_next_s = mask_r;
        end
        if (capture_s) begin
            mask_next_s = mask_next_s | an_low_s;
        end else begin
            mask_next_s = mask_next_s;
        end
        frame_next_s = frame_r;
        for (int i = 0; i < 4; i++) begin
            if (capture_s && an_low_s[i]) begin
                frame_next_s[i*4 +: 4] = dec_s[3:0];
            end else begin
                frame_next_s[i*4 +: 4] = frame_r[i*4 +: 4];
            end
        end
        if (mask_next_s == 4'hF) begin
            state_next_s = ST_COMMIT;
        end else if (!window_s) begin
            state_next_s = ST_IDLE;
        end else if (sampled_next_s) begin
            state_next_s = ST_SAMPLED;
        end else begin
            state_next_s = ST_SETTLING;
        end
    end

    // Receiver state, input registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_r           <= 11'd0;
            prev_r         <= 11'd0;
            cnt_r          <= 8'd0;
            sampled_r      <= 1'b0;
            mask_r         <= 4'd0;
            frame_r        <= 16'd0;
            state_r        <= ST_IDLE;
            data_out_r     <= 16'd0;
            data_valid_r   <= 1'b0;
            seg_error_r    <= 1'b0;
            scan_timeout_r <= 1'b0;
        end else begin
            in_r           <= {an3, an2, an1, an0, a, b, c, d, e, f, g};
            prev_r         <= in_r;
            cnt_r          <= cnt_next_s;
            sampled_r      <= sampled_next_s;
            mask_r         <= mask_next_s;
            frame_r        <= frame_next_s;
            state_r        <= state_next_s;
            data_out_r     <= commit_s ? frame_r : data_out_r;
            data_valid_r   <= commit_s;
            seg_error_r    <= sample_s && !dec_s[4];
            scan_timeout_r <= timeout_s;
        end
    end

    assign data_out     = data_out_r;
    assign data_valid   = data_valid_r;
    assign seg_error    = seg_error_r;
    assign scan_timeout = scan_timeout_r;

endmodule

// File: tb/tb_led_scan_receiver.sv
// ---------------------------------------------------------------------------
// tb_led_scan_receiver
//   Directed, table-driven bench for led_scan_receiver with default
//   parameters (SETTLE_CYCLES=8, TIMEOUT_CYCLES=1024). Inputs change on the
//   falling edge; outputs are observed on the falling edge.
// ---------------------------------------------------------------------------
module tb_led_scan_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        an3, an2, an1, an0;
    logic        a, b, c, d, e, f, g;
    logic        dp;
    logic [15:0] data_out;
    logic        data_valid;
    logic        seg_error;
    logic        scan_timeout;

    logic [3:0]  an_v;
    logic [6:0]  seg_v;

    assign {an3, an2, an1, an0} = an_v;
    assign {a, b, c, d, e, f, g} = seg_v;

    always #5 clk = ~clk;

    led_scan_receiver dut (
        .clk(clk), .reset(reset),
        .an3(an3), .an2(an2), .an1(an1), .an0(an0),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
        .data_out(data_out), .data_valid(data_valid),
        .seg_error(seg_error), .scan_timeout(scan_timeout)
    );

    logic [6:0] seg_tab [16];

    int errors = 0;
    int checks = 0;
    int dv_cnt = 0, se_cnt = 0, to_cnt = 0;
    int dv_long = 0, se_long = 0, to_long = 0;
    logic dv_prev = 1'b0, se_prev = 1'b0, to_prev = 1'b0;

    // Pulse counting and pulse-width monitoring.
    always @(negedge clk) begin
        if (data_valid)   dv_cnt++;
        if (seg_error)    se_cnt++;
        if (scan_timeout) to_cnt++;
        if (data_valid && dv_prev)   dv_long++;
        if (seg_error && se_prev)    se_long++;
        if (scan_timeout && to_prev) to_long++;
        dv_prev = data_valid;
        se_prev = seg_error;
        to_prev = scan_timeout;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_v  = an;
        seg_v = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic win(input int idx, input logic [3:0] digit, input int n);
        logic [3:0] one;
        one = 4'b0001 << idx;
        hold(~one, seg_tab[digit], n);
    endtask

    task automatic blank(input int n);
        hold(4'hF, 7'h7F, n);
    endtask

    // One rotation in the order an2, an1, an0, an3, then a short blank.
    task automatic rotation(input logic [15:0] w, input int n);
        win(2, w[11:8], n);
        win(1, w[7:4], n);
        win(0, w[3:0], n);
        win(3, w[15:12], n);
        blank(4);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        blank(3);
        check({tag, "_rst_data_out"}, {16'd0, data_out}, 32'h0);
        check({tag, "_rst_pulses"}, {29'd0, data_valid, seg_error, scan_timeout}, 32'h0);
        reset = 1'b1;
        blank(2);
    endtask

    typedef struct {
        logic [15:0] word;
        int          win_len;
        int          exp_valid;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int dv0, se0, to0;

        seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
        seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
        seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
        seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
        seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
        seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;

        vecs[0] = '{16'h3A7F, 16, 1, 16'h3A7F};
        vecs[1] = '{16'h3A7F, 16, 1, 16'h3A7F};
        vecs[2] = '{16'h0123, 16, 1, 16'h0123};
        vecs[3] = '{16'h4567, 16, 1, 16'h4567};
        vecs[4] = '{16'h89AB, 16, 1, 16'h89AB};
        vecs[5] = '{16'hCDEF, 16, 1, 16'hCDEF};
        vecs[6] = '{16'h1111, 5,  0, 16'hCDEF};  // too short to settle
        vecs[7] = '{16'h5555, 8,  0, 16'hCDEF};  // one cycle short of settling
        vecs[8] = '{16'h5555, 9,  1, 16'h5555};  // shortest window that settles

        reset = 1'b0;
        dp    = 1'b1;
        an_v  = 4'hF;
        seg_v = 7'h7F;
        @(negedge clk);
        do_reset("init");

        // Table-driven full rotations.
        for (int i = 0; i < 9; i++) begin
            dv0 = dv_cnt;
            se0 = se_cnt;
            rotation(vecs[i].word, vecs[i].win_len);
            check($sformatf("vec%0d_valid_count", i), dv_cnt - dv0, vecs[i].exp_valid);
            check($sformatf("vec%0d_data_out", i), {16'd0, data_out}, {16'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_seg_error", i), se_cnt - se0, 0);
        end

        // Invalid pattern on an1, then a valid rotation completes the frame.
        do_reset("bad");
        dv0 = dv_cnt;
        se0 = se_cnt;
        win(2, 4'h2, 16);
        hold(4'b1101, 7'h7F, 16);
        win(0, 4'h4, 16);
        win(3, 4'h1, 16);
        blank(4);
        check("bad_seg_error_count", se_cnt - se0, 1);
        check("bad_no_valid", dv_cnt - dv0, 0);
        dv0 = dv_cnt;
        rotation(16'h1234, 16);
        check("bad_recover_valid", dv_cnt - dv0, 1);
        check("bad_recover_data", {16'd0, data_out}, 32'h1234);

        // Two anodes low together is blank: no capture, no pulses.
        do_reset("dbl");
        dv0 = dv_cnt;
        se0 = se_cnt;
        hold(4'b0110, seg_tab[8], 20);
        blank(4);
        check("dbl_no_pulses", (dv_cnt - dv0) + (se_cnt - se0), 0);
        win(2, 4'h6, 16);
        win(1, 4'h5, 16);
        win(0, 4'h4, 16);
        blank(4);
        check("dbl_no_capture", dv_cnt - dv0, 0);
        win(3, 4'h7, 16);
        blank(4);
        check("dbl_then_valid", dv_cnt - dv0, 1);
        check("dbl_data", {16'd0, data_out}, 32'h7654);

        // Reset mid-frame discards the three captured digits.
        win(2, 4'h1, 16);
        win(1, 4'h1, 16);
        win(0, 4'h1, 16);
        do_reset("mid");
        dv0 = dv_cnt;
        win(3, 4'hB, 16);
        win(2, 4'hE, 16);
        win(1, 4'hE, 16);
        win(0, 4'hF, 16);
        blank(4);
        check("mid_valid_once", dv_cnt - dv0, 1);
        check("mid_data", {16'd0, data_out}, 32'hBEEF);

        // Partial frame followed by a long blank.
        dv0 = dv_cnt;
        to0 = to_cnt;
        win(3, 4'h9, 16);
        blank(1100);
`ifdef SCAN_TIMEOUT_EN
        check("timeout_pulse", to_cnt - to0, 1);
`else
        check("timeout_absent", to_cnt - to0, 0);
`endif
        win(2, 4'h8, 16);
        win(1, 4'h7, 16);
        win(0, 4'h6, 16);
        blank(4);
`ifdef SCAN_TIMEOUT_EN
        check("timeout_mask_cleared", dv_cnt - dv0, 0);
`else
        check("partial_persists_valid", dv_cnt - dv0, 1);
        check("partial_persists_data", {16'd0, data_out}, 32'h9876);
`endif

        check("pulse_width_data_valid", dv_long, 0);
        check("pulse_width_seg_error", se_long, 0);
        check("pulse_width_scan_timeout", to_long, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
